collision_scheduler: RTL

- Time-multiplexed collision engine for the game frame loop. One rectangle-overlap comparator is shared across all object pairs.
- On a frame start pulse it latches every object position and active bit, then scans three phases, one pair per cycle:
  - player bullets vs enemies
  - player bullets vs enemy bullets
  - enemy bullets vs player
- Produces kill masks that the object managers apply before the next frame.
- Replaces the fully parallel comparator array to save area.

---
 rtl/collision_scheduler.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/collision_scheduler.sv
// Time-multiplexed collision engine: latches all object boxes on a frame start
// and scans every bullet/target pair through one shared overlap comparator.
module collision_scheduler #(
  parameter int unsigned MAX_ENEMY         = 8,
  parameter int unsigned MAX_ENEMY_BULLET  = 16,
  parameter int unsigned MAX_PLAYER_BULLET = 8,
  parameter int unsigned ENEMY_WIDTH       = 32,
  parameter int unsigned ENEMY_HEIGHT      = 32,
  parameter int unsigned BULLET_WIDTH      = 4,
  parameter int unsigned BULLET_HEIGHT     = 8,
  parameter int unsigned PLAYER_WIDTH      = 32,
  parameter int unsigned PLAYER_HEIGHT     = 32,
  parameter int unsigned PLAYER_CENTER_Y   = 440
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst_n,
  input  logic                             i_Start,
  input  logic [MAX_ENEMY-1:0]             i_EnemyState,
  input  logic [MAX_ENEMY_BULLET-1:0]      i_EnemyBulletState,
  input  logic                             i_PlayerState,
  input  logic [MAX_PLAYER_BULLET-1:0]     i_PlayerBulletState,
  input  logic [19*MAX_ENEMY-1:0]          i_EnemyPosition,
  input  logic [19*MAX_ENEMY_BULLET-1:0]   i_EnemyBulletPosition,
  input  logic [19*MAX_PLAYER_BULLET-1:0]  i_PlayerBulletPosition,
  input  logic [9:0]                       i_PlayerPosition,
  output logic                             o_Busy,
  output logic                             o_Done,
  output logic [MAX_ENEMY-1:0]             o_EnemyKill,
  output logic [MAX_ENEMY_BULLET-1:0]      o_EnemyBulletKill,
  output logic [MAX_PLAYER_BULLET-1:0]     o_PlayerBulletKill,
  output logic                             o_PlayerHit
);

  localparam int unsigned POS_W = 19;
  localparam int unsigned PB_IW = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;
  localparam int unsigned EN_IW = (MAX_ENEMY > 1) ? $clog2(MAX_ENEMY) : 1;
  localparam int unsigned EB_IW = (MAX_ENEMY_BULLET > 1) ? $clog2(MAX_ENEMY_BULLET) : 1;
  localparam int unsigned IN_IW = (EN_IW > EB_IW) ? EN_IW : EB_IW;

  localparam logic [10:0] EN_W = 11'(ENEMY_WIDTH);
  localparam logic [9:0]  EN_H = 10'(ENEMY_HEIGHT);
  localparam logic [10:0] BU_W = 11'(BULLET_WIDTH);
  localparam logic [9:0]  BU_H = 10'(BULLET_HEIGHT);
  localparam logic [10:0] PL_W = 11'(PLAYER_WIDTH);
  localparam logic [9:0]  PL_H = 10'(PLAYER_HEIGHT);
  localparam logic [8:0]  PL_Y = 9'(PLAYER_CENTER_Y);

  localparam logic [PB_IW-1:0] PB_LAST = PB_IW'(MAX_PLAYER_BULLET - 1);
  localparam logic [IN_IW-1:0] EN_LAST = IN_IW'(MAX_ENEMY - 1);
  localparam logic [IN_IW-1:0] EB_LAST = IN_IW'(MAX_ENEMY_BULLET - 1);

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } pos_t;

  typedef enum logic [2:0] {IDLE, PB_EN, PB_EB, EB_PL, DONE} state_t;

  state_t            state, nextState;
  logic [PB_IW-1:0]  outerCnt, nextOuter;
  logic [IN_IW-1:0]  innerCnt, nextInner;
  logic              latchInputs;

  pos_t                         enemyPos  [MAX_ENEMY];
  pos_t                         ebPos     [MAX_ENEMY_BULLET];
  pos_t                         pbPos     [MAX_PLAYER_BULLET];
  logic [MAX_ENEMY-1:0]         enemyAct;
  logic [MAX_ENEMY_BULLET-1:0]  ebAct;
  logic [MAX_PLAYER_BULLET-1:0] pbAct;
  logic                         playerAct;
  logic [9:0]                   playerX;

  logic [PB_IW-1:0] pbIdx;
  logic [EN_IW-1:0] enIdx;
  logic [EB_IW-1:0] ebIdx;

  pos_t        aPos, bPos;
  logic [10:0] aW, bW;
  logic [9:0]  aH, bH;
  logic        pairValid;
  logic        pairHit;

  assign pbIdx = outerCnt;
  assign enIdx = innerCnt[EN_IW-1:0];
  assign ebIdx = innerCnt[EB_IW-1:0];

  // State and scan counters
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state    <= IDLE;
      outerCnt <= '0;
      innerCnt <= '0;
      o_Busy   <= 1'b0;
      o_Done   <= 1'b0;
    end else begin
      state    <= nextState;
      outerCnt <= nextOuter;
      innerCnt <= nextInner;
      o_Busy   <= (nextState != IDLE);
      o_Done   <= (state == DONE);
    end
  end

  // Phase sequencing: outer index over player bullets, inner over targets
  always_comb begin
    nextState   = state;
    nextOuter   = outerCnt;
    nextInner   = innerCnt;
    latchInputs = 1'b0;
    case (state)
      IDLE: begin
        if (i_Start) begin
          nextState   = PB_EN;
          nextOuter   = '0;
          nextInner   = '0;
          latchInputs = 1'b1;
        end
      end
      PB_EN: begin
        if (innerCnt == EN_LAST) begin
          nextInner = '0;
          if (outerCnt == PB_LAST) begin
            nextOuter = '0;
            nextState = PB_EB;
          end else begin
            nextOuter = outerCnt + PB_IW'(1);
          end
        end else begin
          nextInner = innerCnt + IN_IW'(1);
        end
      end
      PB_EB: begin
        if (innerCnt == EB_LAST) begin
          nextInner = '0;
          if (outerCnt == PB_LAST) begin
            nextOuter = '0;
            nextState = EB_PL;
          end else begin
            nextOuter = outerCnt + PB_IW'(1);
          end
        end else begin
          nextInner = innerCnt + IN_IW'(1);
        end
      end
      EB_PL: begin
        if (innerCnt == EB_LAST) begin
          nextInner = '0;
          nextState = DONE;
        end else begin
          nextInner = innerCnt + IN_IW'(1);
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Select the box pair for the current scan slot
  always_comb begin
    aPos      = '0;
    bPos      = '0;
    aW        = '0;
    aH        = '0;
    bW        = '0;
    bH        = '0;
    pairValid = 1'b0;
    case (state)
      PB_EN: begin
        aPos      = pbPos[pbIdx];
        aW        = BU_W;
        aH        = BU_H;
        bPos      = enemyPos[enIdx];
        bW        = EN_W;
        bH        = EN_H;
        pairValid = pbAct[pbIdx] & enemyAct[enIdx];
      end
      PB_EB: begin
        aPos      = pbPos[pbIdx];
        aW        = BU_W;
        aH        = BU_H;
        bPos      = ebPos[ebIdx];
        bW        = BU_W;
        bH        = BU_H;
        pairValid = pbAct[pbIdx] & ebAct[ebIdx];
      end
      EB_PL: begin
        aPos      = ebPos[ebIdx];
        aW        = BU_W;
        aH        = BU_H;
        bPos.x    = playerX;
        bPos.y    = PL_Y;
        bW        = PL_W;
        bH        = PL_H;
        pairValid = ebAct[ebIdx] & playerAct;
      end
      default: pairValid = 1'b0;
    endcase
  end

  // Shared overlap comparator; widened sums keep the screen edge from wrapping
  always_comb begin
    pairHit = (11'(aPos.x) < (11'(bPos.x) + bW)) &
              (11'(bPos.x) < (11'(aPos.x) + aW)) &
              (10'(aPos.y) < (10'(bPos.y) + bH)) &
              (10'(bPos.y) < (10'(aPos.y) + aH));
  end

  // Frame snapshot of object state
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      enemyAct  <= '0;
      ebAct     <= '0;
      pbAct     <= '0;
      playerAct <= 1'b0;
      playerX   <= '0;
      for (int i = 0; i < MAX_ENEMY; i++)         enemyPos[i] <= '0;
      for (int i = 0; i < MAX_ENEMY_BULLET; i++)  ebPos[i]    <= '0;
      for (int i = 0; i < MAX_PLAYER_BULLET; i++) pbPos[i]    <= '0;
    end else if (latchInputs) begin
      enemyAct  <= i_EnemyState;
      ebAct     <= i_EnemyBulletState;
      pbAct     <= i_PlayerBulletState;
      playerAct <= i_PlayerState;
      playerX   <= i_PlayerPosition;
      for (int i = 0; i < MAX_ENEMY; i++)
        enemyPos[i] <= i_EnemyPosition[POS_W*i +: POS_W];
      for (int i = 0; i < MAX_ENEMY_BULLET; i++)
        ebPos[i] <= i_EnemyBulletPosition[POS_W*i +: POS_W];
      for (int i = 0; i < MAX_PLAYER_BULLET; i++)
        pbPos[i] <= i_PlayerBulletPosition[POS_W*i +: POS_W];
    end
  end

  // Sticky kill masks, cleared when a new frame is accepted
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_EnemyKill        <= '0;
      o_EnemyBulletKill  <= '0;
      o_PlayerBulletKill <= '0;
      o_PlayerHit        <= 1'b0;
    end else if (latchInputs) begin
      o_EnemyKill        <= '0;
      o_EnemyBulletKill  <= '0;
      o_PlayerBulletKill <= '0;
      o_PlayerHit        <= 1'b0;
    end else if (pairValid && pairHit) begin
      case (state)
        PB_EN: begin
          o_PlayerBulletKill[pbIdx] <= 1'b1;
          o_EnemyKill[enIdx]        <= 1'b1;
        end
        PB_EB: begin
          o_PlayerBulletKill[pbIdx] <= 1'b1;
          o_EnemyBulletKill[ebIdx]  <= 1'b1;
        end
        EB_PL: begin
          o_EnemyBulletKill[ebIdx] <= 1'b1;
          o_PlayerHit              <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
